branch_resolve_unit: RTL and testbench
======================================

Name: branch_resolve_unit

Overview:
- EX-stage consumer of the branch comparator's 1-bit result.
- Resolves BEQ/BNE/BLT/BGE/BLTU/BGEU, JAL and JALR against the fetch-stage prediction.
- Computes the actual next PC and, on mispredict, issues a registered redirect to fetch with a valid/ready handshake plus a one-cycle flush of younger IF/ID instructions.
- Also checks target alignment and keeps saturating branch/mispredict counters.

Parameters:
- XLEN, 64, datapath/PC width.
- CNT_W, 32, performance counter width.
- ALIGN_CHECK, 1, when 1 a taken target with target[1:0]!=0 raises misalign_exc instead of redirecting.

Ports:
- clk  in  1  single clock, all state on rising edge.
- reset  in  1  synchronous, active-high.
- ex_valid  in  1  EX instruction valid.
- ex_ready  out  1  EX may accept/advance; equals (state==IDLE).
- ex_pc  in  XLEN  PC of EX instruction.
- ex_opcode  in  7  instruction opcode.
- ex_imm  in  XLEN  sign-extended immediate.
- ex_rs1_data  in  XLEN  rs1 operand (JALR base).
- ex_pred_taken  in  1  fetch predicted taken.
- ex_pred_target  in  XLEN  fetch predicted target.
- branch_compare_result  in  1  condition result from comparator (valid for opcode 1100011 only).
- redirect_valid  out  1  redirect request to fetch.
- redirect_ready  in  1  fetch accepts redirect.
- redirect_pc  out  XLEN  corrected fetch PC, stable while redirect_valid=1.
- flush  out  1  one-cycle kill of younger IF/ID instructions.
- misalign_exc  out  1  one-cycle instruction-address-misaligned pulse.
- misalign_addr  out  XLEN  offending target, valid while misalign_exc=1.
- perf_branches  out  CNT_W  resolved control-flow count.
- perf_mispredicts  out  CNT_W  redirect count.

Behaviour:
- Accept = ex_valid && ex_ready. Control-flow opcodes: 1100011 (branch), 1101111 (JAL), 1100111 (JALR); all other opcodes produce no action.
- actual_taken = branch_compare_result for branch; 1 for JAL/JALR.
- target = ex_pc+ex_imm (branch/JAL); (ex_rs1_data+ex_imm) & ~1 (JALR). Modulo-2^XLEN wrap, no overflow flag.
- next_pc = actual_taken ? target : ex_pc+4 (wraps).
- mispredict = (actual_taken != ex_pred_taken) || (actual_taken && ex_pred_target != target).
- misaligned = ALIGN_CHECK && actual_taken && target[1:0]!=0. It has priority over mispredict.
- FSM states: IDLE, REDIRECT.
  - IDLE, accepted control-flow with misaligned: cycle N+1 misalign_exc=1, misalign_addr=target; flush=0, no redirect; stay IDLE.
  - IDLE, accepted control-flow with mispredict (not misaligned): cycle N+1 redirect_valid=1, redirect_pc=next_pc, flush=1; go REDIRECT.
  - IDLE, otherwise: stay IDLE.
  - REDIRECT: flush=0 after the first cycle. Hold redirect_valid/redirect_pc stable until redirect_ready=1. On the handshake cycle go IDLE; redirect_valid=0 next cycle.
  - REDIRECT: ex_ready=0 and ex_valid is ignored; upstream holds its instruction.
- Minimum redirect occupancy is 1 cycle (ready already high when valid rises → IDLE at N+2). No back-to-back redirects without an intervening IDLE cycle.
- Counters:
  - perf_branches +1 per accepted control-flow instruction, misaligned included.
  - perf_mispredicts +1 per redirect issued.
  - Both saturate at all-ones.
- Reset (synchronous, any state): state=IDLE, redirect_valid=0, redirect_pc=0, flush=0, misalign_exc=0, misalign_addr=0, both counters=0. A pending redirect is dropped.
- flush, misalign_exc, redirect_valid are registered outputs; ex_ready is combinational from state only.

Test Plan:
- Correct not-taken: BEQ pc=0x1000, imm=0x40, compare=0, pred_taken=0 → no redirect, flush=0, perf_branches=1, perf_mispredicts=0.
- Taken mispredict: BNE pc=0x1000, imm=0x40, compare=1, pred_taken=0, redirect_ready=1 → N+1 redirect_valid=1, redirect_pc=0x1040, flush=1 for one cycle; N+2 redirect_valid=0, ex_ready=1; perf_mispredicts=1.
- JALR target mismatch with fetch stall: rs1=0x2001, imm=0x10, pred_taken=1, pred_target=0x3000, redirect_ready low 3 cycles → redirect_pc=0x2010 held 4 cycles; ex_ready=0 throughout and ex_valid ignored; release one cycle after ready.
- Wrap and fall-through: BLT pc=0xFFFF_FFFF_FFFF_FFFC, compare=0, pred_taken=1 → redirect_pc=0x0.
- Misaligned: JAL pc=0x1000, imm=0x6 → misalign_exc=1 one cycle, misalign_addr=0x1006, no redirect or flush, perf_branches+1.
- Reset mid-REDIRECT with redirect_ready=0 → next cycle redirect_valid=0, ex_ready=1, counters=0. Counter preset near all-ones → saturates, no wrap.

Source files
------------

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: resolves conditional branches, JAL and JALR against the
// fetch prediction. On a mispredict it issues a registered redirect to fetch
// with a valid/ready handshake and a one-cycle flush. A misaligned taken
// target raises a one-cycle exception instead. Branch and mispredict counters
// saturate at all-ones.
module branch_resolve_unit #(
   parameter int XLEN        = 64,
   parameter int CNT_W       = 32,
   parameter bit ALIGN_CHECK = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             ex_valid,
   output logic             ex_ready,
   input  logic [XLEN-1:0]  ex_pc,
   input  logic [6:0]       ex_opcode,
   input  logic [XLEN-1:0]  ex_imm,
   input  logic [XLEN-1:0]  ex_rs1_data,
   input  logic             ex_pred_taken,
   input  logic [XLEN-1:0]  ex_pred_target,
   input  logic             branch_compare_result,
   output logic             redirect_valid,
   input  logic             redirect_ready,
   output logic [XLEN-1:0]  redirect_pc,
   output logic             flush,
   output logic             misalign_exc,
   output logic [XLEN-1:0]  misalign_addr,
   output logic [CNT_W-1:0] perf_branches,
   output logic [CNT_W-1:0] perf_mispredicts
);

   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;

   typedef enum logic [0:0] {IDLE = 1'b0, REDIRECT = 1'b1} state_t;

   state_t state_reg, state_next;

   logic            redirect_valid_reg, redirect_valid_next;
   logic [XLEN-1:0] redirect_pc_reg, redirect_pc_next;
   logic            flush_reg, flush_next;
   logic            misalign_exc_reg, misalign_exc_next;
   logic [XLEN-1:0] misalign_addr_reg, misalign_addr_next;

   // Resolution datapath
   logic            is_branch, is_jal, is_jalr, is_cf;
   logic            accept;
   logic [XLEN-1:0] target_base, target_sum, target, fall_through, next_pc;
   logic            actual_taken, mispredict, misaligned;
   logic            take_redirect, take_exc;

   // Decode the opcode and compute target, next PC and prediction outcome
   always_comb begin
      is_branch    = (ex_opcode == OP_BRANCH);
      is_jal       = (ex_opcode == OP_JAL);
      is_jalr      = (ex_opcode == OP_JALR);
      is_cf        = is_branch || is_jal || is_jalr;
      accept       = ex_valid && (state_reg == IDLE);
      target_base  = is_jalr ? ex_rs1_data : ex_pc;
      target_sum   = target_base + ex_imm;
      // JALR clears bit 0 of the computed address
      target       = is_jalr ? {target_sum[XLEN-1:1], 1'b0} : target_sum;
      actual_taken = is_branch ? branch_compare_result : 1'b1;
      fall_through = ex_pc + XLEN'(4);
      next_pc      = actual_taken ? target : fall_through;
      mispredict   = (actual_taken != ex_pred_taken) ||
                     (actual_taken && (ex_pred_target != target));
      misaligned   = ALIGN_CHECK && actual_taken && (target[1:0] != 2'b00);
      // Misalignment wins over mispredict: the exception path never redirects
      take_exc      = accept && is_cf && misaligned;
      take_redirect = accept && is_cf && !misaligned && mispredict;
   end

   // State register
   always_ff @(posedge clk) begin
      if (reset) state_reg <= IDLE;
      else       state_reg <= state_next;
   end

   // Next-state logic: enter REDIRECT on a mispredict, leave on handshake
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:     if (take_redirect) state_next = REDIRECT;
         REDIRECT: if (redirect_ready) state_next = IDLE;
         default:  state_next = IDLE;
      endcase
   end

   // Output logic: next values for the registered handshake/flush/exception outputs
   always_comb begin
      redirect_valid_next = (state_next == REDIRECT);
      redirect_pc_next    = take_redirect ? next_pc : redirect_pc_reg;
      flush_next          = take_redirect;
      misalign_exc_next   = take_exc;
      misalign_addr_next  = take_exc ? target : misalign_addr_reg;
   end

   // Registered outputs toward fetch and the trap logic
   always_ff @(posedge clk) begin
      if (reset) begin
         redirect_valid_reg <= 1'b0;
         redirect_pc_reg    <= '0;
         flush_reg          <= 1'b0;
         misalign_exc_reg   <= 1'b0;
         misalign_addr_reg  <= '0;
      end else begin
         redirect_valid_reg <= redirect_valid_next;
         redirect_pc_reg    <= redirect_pc_next;
         flush_reg          <= flush_next;
         misalign_exc_reg   <= misalign_exc_next;
         misalign_addr_reg  <= misalign_addr_next;
      end
   end

   // Saturating performance counters: index 0 counts resolved control flow,
   // index 1 counts redirects issued
   logic [CNT_W-1:0] cnt_reg  [2];
   logic [CNT_W-1:0] cnt_next [2];
   logic             cnt_inc  [2];

   assign cnt_inc[0] = accept && is_cf;
   assign cnt_inc[1] = take_redirect;

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
         // Increment unless already at all-ones
         always_comb begin
            cnt_next[gi] = cnt_reg[gi];
            if (cnt_inc[gi] && (cnt_reg[gi] != {CNT_W{1'b1}}))
               cnt_next[gi] = cnt_reg[gi] + CNT_W'(1);
         end

         // Counter register
         always_ff @(posedge clk) begin
            if (reset) cnt_reg[gi] <= '0;
            else       cnt_reg[gi] <= cnt_next[gi];
         end
      end
   endgenerate

   assign ex_ready         = (state_reg == IDLE);
   assign redirect_valid   = redirect_valid_reg;
   assign redirect_pc      = redirect_pc_reg;
   assign flush            = flush_reg;
   assign misalign_exc     = misalign_exc_reg;
   assign misalign_addr    = misalign_addr_reg;
   assign perf_branches    = cnt_reg[0];
   assign perf_mispredicts = cnt_reg[1];

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Testbench for branch_resolve_unit: directed scenarios followed by random
// traffic, checked each cycle against a transaction-level reference model.
module tb_branch_resolve_unit;

   localparam int XLEN  = 64;
   localparam int CNT_W = 6;
   localparam int CMAX  = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             reset;
   logic             ex_valid;
   logic             ex_ready;
   logic [XLEN-1:0]  ex_pc;
   logic [6:0]       ex_opcode;
   logic [XLEN-1:0]  ex_imm;
   logic [XLEN-1:0]  ex_rs1_data;
   logic             ex_pred_taken;
   logic [XLEN-1:0]  ex_pred_target;
   logic             branch_compare_result;
   logic             redirect_valid;
   logic             redirect_ready;
   logic [XLEN-1:0]  redirect_pc;
   logic             flush;
   logic             misalign_exc;
   logic [XLEN-1:0]  misalign_addr;
   logic [CNT_W-1:0] perf_branches;
   logic [CNT_W-1:0] perf_mispredicts;

   branch_resolve_unit #(.XLEN(XLEN), .CNT_W(CNT_W), .ALIGN_CHECK(1'b1)) dut (
      .clk(clk), .reset(reset),
      .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_pc(ex_pc),
      .ex_opcode(ex_opcode), .ex_imm(ex_imm), .ex_rs1_data(ex_rs1_data),
      .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
      .branch_compare_result(branch_compare_result),
      .redirect_valid(redirect_valid), .redirect_ready(redirect_ready),
      .redirect_pc(redirect_pc), .flush(flush),
      .misalign_exc(misalign_exc), .misalign_addr(misalign_addr),
      .perf_branches(perf_branches), .perf_mispredicts(perf_mispredicts)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model state: a pending redirect plus last-cycle pulses
   bit              m_busy;
   logic [XLEN-1:0] m_rpc;
   bit              m_flush;
   bit              m_exc;
   logic [XLEN-1:0] m_addr;
   int              m_br;
   int              m_mp;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Apply the architectural rules to the inputs presented at this edge
   task automatic model_step();
      bit              cf, taken, mis, mp;
      logic [XLEN-1:0] tgt, nxt;
      if (reset) begin
         m_busy = 0; m_rpc = '0; m_flush = 0; m_exc = 0; m_addr = '0;
         m_br = 0; m_mp = 0;
         return;
      end
      m_flush = 0;
      m_exc   = 0;
      if (m_busy) begin
         if (redirect_ready) m_busy = 0;
         return;
      end
      cf = (ex_opcode == 7'h63) || (ex_opcode == 7'h6F) || (ex_opcode == 7'h67);
      if (!(ex_valid && cf)) return;
      if (ex_opcode == 7'h67) tgt = (ex_rs1_data + ex_imm) & ~64'd1;
      else                    tgt = ex_pc + ex_imm;
      taken = (ex_opcode == 7'h63) ? branch_compare_result : 1'b1;
      nxt   = taken ? tgt : ex_pc + 64'd4;
      mis   = taken && (tgt % 4 != 0);
      mp    = (taken != ex_pred_taken) || (taken && ex_pred_target != tgt);
      if (m_br < CMAX) m_br++;
      if (mis) begin
         m_exc = 1; m_addr = tgt;
      end else if (mp) begin
         m_busy = 1; m_rpc = nxt; m_flush = 1;
         if (m_mp < CMAX) m_mp++;
      end
   endtask

   task automatic check_all();
      chk("ex_ready", 64'(ex_ready), 64'(!m_busy));
      chk("redirect_valid", 64'(redirect_valid), 64'(m_busy));
      chk("flush", 64'(flush), 64'(m_flush));
      chk("misalign_exc", 64'(misalign_exc), 64'(m_exc));
      chk("perf_branches", 64'(perf_branches), 64'(m_br));
      chk("perf_mispredicts", 64'(perf_mispredicts), 64'(m_mp));
      if (m_busy) chk("redirect_pc", redirect_pc, m_rpc);
      if (m_exc)  chk("misalign_addr", misalign_addr, m_addr);
   endtask

   task automatic cycle(input string what);
      model_step();
      @(posedge clk);
      #1;
      check_all();
      $display("cyc %-10s v=%0b op=%h pc=%h | rv=%0b rpc=%h fl=%0b exc=%0b br=%0d mp=%0d",
               what, ex_valid, ex_opcode, ex_pc, redirect_valid, redirect_pc,
               flush, misalign_exc, perf_branches, perf_mispredicts);
   endtask

   task automatic drive(input logic v, input logic [6:0] op, input logic [63:0] pc,
                        input logic [63:0] imm, input logic [63:0] rs1, input logic cmp,
                        input logic pt, input logic [63:0] ptgt);
      ex_valid = v; ex_opcode = op; ex_pc = pc; ex_imm = imm; ex_rs1_data = rs1;
      branch_compare_result = cmp; ex_pred_taken = pt; ex_pred_target = ptgt;
   endtask

   initial begin
      logic [6:0]  ops [4];
      logic [63:0] rpc, rimm, rtgt;
      ops[0] = 7'h63; ops[1] = 7'h6F; ops[2] = 7'h67; ops[3] = 7'h13;

      // Reset
      reset = 1'b1; redirect_ready = 1'b1;
      drive(0, 7'h13, 0, 0, 0, 0, 0, 0);
      cycle("reset");
      cycle("reset");
      chk("rst_redirect_pc", redirect_pc, 64'h0);
      chk("rst_misalign_addr", misalign_addr, 64'h0);
      reset = 1'b0;

      // Correctly predicted not-taken BEQ
      drive(1, 7'h63, 64'h1000, 64'h40, 0, 0, 0, 0);
      cycle("beq_nt");
      chk("beq_nt_branches", 64'(perf_branches), 64'd1);
      chk("beq_nt_redirect", 64'(redirect_valid), 64'd0);

      // Taken BNE predicted not-taken, fetch ready immediately
      drive(1, 7'h63, 64'h1000, 64'h40, 0, 1, 0, 0);
      cycle("bne_mp");
      chk("bne_rpc", redirect_pc, 64'h1040);
      chk("bne_flush", 64'(flush), 64'd1);
      drive(0, 7'h13, 0, 0, 0, 0, 0, 0);
      cycle("bne_rel");
      chk("bne_ready", 64'(ex_ready), 64'd1);
      chk("bne_mispredicts", 64'(perf_mispredicts), 64'd1);

      // JALR target mismatch while fetch stalls; EX presents another instruction
      redirect_ready = 1'b0;
      drive(1, 7'h67, 64'h1100, 64'h10, 64'h2001, 0, 1, 64'h3000);
      cycle("jalr_mp");
      drive(1, 7'h63, 64'h5000, 64'h80, 0, 1, 0, 0);
      for (int i = 0; i < 3; i++) cycle("jalr_hold");
      chk("jalr_rpc", redirect_pc, 64'h2010);
      redirect_ready = 1'b1;
      drive(0, 7'h13, 0, 0, 0, 0, 0, 0);
      cycle("jalr_rel");

      // BLT at the top of the address space falls through and wraps to 0
      drive(1, 7'h63, 64'hFFFF_FFFF_FFFF_FFFC, 64'h40, 0, 0, 1, 64'h40);
      cycle("blt_wrap");
      chk("wrap_rpc", redirect_pc, 64'h0);
      drive(0, 7'h13, 0, 0, 0, 0, 0, 0);
      cycle("idle");

      // Misaligned JAL target
      drive(1, 7'h6F, 64'h1000, 64'h6, 0, 0, 1, 64'h1006);
      cycle("jal_mis");
      chk("mis_addr", misalign_addr, 64'h1006);
      drive(0, 7'h13, 0, 0, 0, 0, 0, 0);
      cycle("idle");

      // Reset while a redirect is stalled
      redirect_ready = 1'b0;
      drive(1, 7'h6F, 64'h2000, 64'h100, 0, 0, 0, 0);
      cycle("jal_mp");
      drive(0, 7'h13, 0, 0, 0, 0, 0, 0);
      cycle("stall");
      reset = 1'b1;
      cycle("reset_mid");
      reset = 1'b0;
      chk("rst_mid_valid", 64'(redirect_valid), 64'd0);
      chk("rst_mid_branches", 64'(perf_branches), 64'd0);

      // Random traffic; long enough for both counters to saturate
      for (int n = 0; n < 700; n++) begin
         redirect_ready = ($urandom_range(0, 2) != 0);
         rpc  = {$urandom, $urandom} & ~64'd3;
         rimm = {32'(0), $urandom_range(0, 4096) * 4};
         if ($urandom_range(0, 5) == 0) rimm = rimm | 64'($urandom_range(1, 3));
         if ($urandom_range(0, 1) == 0) rimm = -rimm;
         rtgt = ($urandom_range(0, 2) == 0) ? rpc + rimm : {$urandom, $urandom} & ~64'd3;
         drive(($urandom_range(0, 3) != 0), ops[$urandom_range(0, 3)], rpc, rimm,
               {$urandom, $urandom}, 1'($urandom), 1'($urandom), rtgt);
         cycle("rand");
      end
      chk("sat_branches", 64'(perf_branches), 64'(CMAX));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
